bp_resolve: RTL and testbench

//  Branch-resolution end of the prediction path: queues each IF/ID prediction (B-type, JAL), matches it in

---
 rtl/bp_resolve_pkg.sv | 28 ++
 rtl/bp_pred_fifo.sv | 57 +++++
 rtl/bp_resolve.sv | 132 +++++++++++++
 tb/tb_bp_resolve.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_resolve_pkg.sv
// Shared types and constants for the branch-resolution block.
package bp_resolve_pkg;

  localparam int unsigned INST_ADDR_W          = 32;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  localparam inst_addr_t ZERO_WORD = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bp_state_t;

  // One in-flight prediction as issued by ID.
  typedef struct packed {
    inst_addr_t pc;
    logic       taken;
    inst_addr_t addr;
  } pred_entry_t;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// In-order queue of outstanding predictions. Push while full is dropped unless
// a pop happens in the same cycle; pop while empty is ignored; clear wins over both.
module bp_pred_fifo
  import bp_resolve_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t wdata,
  output pred_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pred_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  // A pop in the same cycle frees the slot being written, so push at full is legal then.
  assign do_push = push & ~clear & (~full | (pop & ~empty));
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bp_resolve.sv
// Branch resolution: matches queued predictions against EX outcomes in order,
// raises flush/redirect on mispredict, emits predictor training and keeps stats.
module bp_resolve
  import bp_resolve_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        pred_valid_i,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_addr_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_target_i,
  output logic        flush_o,
  output logic [31:0] redirect_addr_o,
  output logic        upd_valid_o,
  output logic        upd_taken_o,
  output logic [31:0] upd_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o,
  output logic        err_o
);

  localparam int unsigned FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  bp_state_t    state;
  logic [FCW-1:0] flush_cnt;

  pred_entry_t  push_entry;
  pred_entry_t  head;
  logic         q_full;
  logic         q_empty;

  logic         idle;
  logic         push_req;
  logic         pop_req;
  logic         overflow;
  logic         head_taken;
  inst_addr_t   head_addr;
  logic         pc_mismatch;
  logic         mispredict;
  logic         err_event;
  inst_addr_t   redirect_next;

  assign push_entry = '{pc: pred_pc_i, taken: pred_taken_i, addr: pred_addr_i};

  bp_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .clear (mispredict),
    .wdata (push_entry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Compare the queue head with the EX outcome; an empty queue reads as predicted not-taken.
  always_comb begin
    idle          = (state == ST_IDLE);
    push_req      = pred_valid_i & ~hold_i & idle;
    pop_req       = ex_valid_i & idle;
    overflow      = push_req & q_full & ~pop_req;
    head_taken    = q_empty ? 1'b0 : head.taken;
    head_addr     = q_empty ? ZERO_WORD : head.addr;
    pc_mismatch   = ~q_empty & (head.pc != ex_pc_i);
    mispredict    = pop_req & ((head_taken != ex_jump_i) |
                               (ex_jump_i & (head_addr != ex_target_i)) |
                               pc_mismatch);
    err_event     = overflow | (pop_req & q_empty) | (pop_req & pc_mismatch);
    redirect_next = ex_jump_i ? ex_target_i : ex_pc_i + 32'd4;
  end

  // Resolution FSM with registered flush/redirect, training strobe and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      flush_cnt       <= '0;
      flush_o         <= 1'b0;
      redirect_addr_o <= ZERO_WORD;
      upd_valid_o     <= 1'b0;
      upd_taken_o     <= 1'b0;
      upd_pc_o        <= ZERO_WORD;
      branch_cnt_o    <= '0;
      mispred_cnt_o   <= '0;
      err_o           <= 1'b0;
    end else begin
      upd_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_req) begin
            upd_valid_o  <= 1'b1;
            upd_taken_o  <= ex_jump_i;
            upd_pc_o     <= ex_pc_i;
            branch_cnt_o <= sat_inc(branch_cnt_o);
          end
          if (mispredict) begin
            mispred_cnt_o   <= sat_inc(mispred_cnt_o);
            flush_o         <= 1'b1;
            redirect_addr_o <= redirect_next;
            flush_cnt       <= FLUSH_LOAD;
            state           <= ST_FLUSH;
          end
          if (err_event) err_o <= 1'b1;
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            flush_o <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        default: begin
          flush_o <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_resolve.sv
// Scoreboard bench for bp_resolve: a queue-based reference model predicts
// training updates, flush windows, error flag and counters.
module tb_bp_resolve;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_i;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_addr_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_jump_i;
  logic [31:0] ex_target_i;
  logic        flush_o;
  logic [31:0] redirect_addr_o;
  logic        upd_valid_o;
  logic        upd_taken_o;
  logic [31:0] upd_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;
  logic        err_o;

  always #5 clk = ~clk;

  bp_resolve #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hold_i          (hold_i),
    .pred_valid_i    (pred_valid_i),
    .pred_pc_i       (pred_pc_i),
    .pred_taken_i    (pred_taken_i),
    .pred_addr_i     (pred_addr_i),
    .ex_valid_i      (ex_valid_i),
    .ex_pc_i         (ex_pc_i),
    .ex_jump_i       (ex_jump_i),
    .ex_target_i     (ex_target_i),
    .flush_o         (flush_o),
    .redirect_addr_o (redirect_addr_o),
    .upd_valid_o     (upd_valid_o),
    .upd_taken_o     (upd_taken_o),
    .upd_pc_o        (upd_pc_o),
    .branch_cnt_o    (branch_cnt_o),
    .mispred_cnt_o   (mispred_cnt_o),
    .err_o           (err_o)
  );

  typedef struct {
    logic        taken;
    logic [31:0] pc;
  } upd_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] addr;
  } pred_t;

  upd_t        sb[$];
  pred_t       mq[$];
  upd_t        mon_u;
  int unsigned m_flush_left;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;
  logic [31:0] m_redirect;
  logic        m_err;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock cycle of stimulus; the model advances at the edge, outputs checked 1 after.
  task automatic cyc(input bit pv, input logic [31:0] ppc, input bit pt, input logic [31:0] pa,
                     input bit hv, input bit ev, input logic [31:0] epc, input bit ej,
                     input logic [31:0] et);
    pred_t h;
    upd_t  u;
    bit    mis;
    pred_valid_i = pv;
    pred_pc_i    = ppc;
    pred_taken_i = pt;
    pred_addr_i  = pa;
    hold_i       = hv;
    ex_valid_i   = ev;
    ex_pc_i      = epc;
    ex_jump_i    = ej;
    ex_target_i  = et;
    @(posedge clk);
    if (m_flush_left != 0) begin
      m_flush_left--;
    end else begin
      mis = 1'b0;
      if (ev) begin
        if (mq.size() == 0) begin
          h.pc = epc; h.taken = 1'b0; h.addr = 32'd0;
          m_err = 1'b1;
        end else begin
          h = mq.pop_front();
          if (h.pc != epc) begin
            m_err = 1'b1;
            mis   = 1'b1;
          end
        end
        if (h.taken != ej) mis = 1'b1;
        if (ej && (h.addr != et)) mis = 1'b1;
        u.taken = ej;
        u.pc    = epc;
        sb.push_back(u);
        m_bcnt = sat(m_bcnt);
      end
      if (pv && !hv) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: ppc, taken: pt, addr: pa});
        else m_err = 1'b1;
      end
      if (mis) begin
        m_mcnt       = sat(m_mcnt);
        m_redirect   = ej ? et : epc + 32'd4;
        m_flush_left = FLUSH;
        mq.delete();
      end
    end
    #1;
    check("flush", {31'd0, flush_o}, {31'd0, m_flush_left != 0});
    if (m_flush_left != 0) check("redirect", redirect_addr_o, m_redirect);
    check("err", {31'd0, err_o}, {31'd0, m_err});
    check("branch_cnt", branch_cnt_o, m_bcnt);
    check("mispred_cnt", mispred_cnt_o, m_mcnt);
  endtask

  task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] a);
    cyc(1'b1, pc, t, a, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic res(input logic [31:0] pc, input bit j, input logic [31:0] t);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, pc, j, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    check("sb_drained", sb.size(), 32'd0);
    rst = 1'b1;
    pred_valid_i = 1'b0; hold_i = 1'b0; ex_valid_i = 1'b0;
    @(posedge clk);
    mq.delete();
    sb.delete();
    m_flush_left = 0;
    m_bcnt = '0; m_mcnt = '0; m_redirect = '0; m_err = 1'b0;
    #1;
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_redirect", redirect_addr_o, 32'd0);
    check("rst_upd_valid", {31'd0, upd_valid_o}, 32'd0);
    check("rst_upd_taken", {31'd0, upd_taken_o}, 32'd0);
    check("rst_upd_pc", upd_pc_o, 32'd0);
    check("rst_branch_cnt", branch_cnt_o, 32'd0);
    check("rst_mispred_cnt", mispred_cnt_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;
  endtask

  // Training monitor: each strobe must match the oldest expected update.
  always @(negedge clk) begin
    if (upd_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("upd_extra", {31'd0, upd_valid_o}, 32'd0);
      end else begin
        mon_u = sb.pop_front();
        check("upd_taken", {31'd0, upd_taken_o}, {31'd0, mon_u.taken});
        check("upd_pc", upd_pc_o, mon_u.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hold_i = 1'b0; pred_valid_i = 1'b0; pred_pc_i = '0; pred_taken_i = 1'b0; pred_addr_i = '0;
    ex_valid_i = 1'b0; ex_pc_i = '0; ex_jump_i = 1'b0; ex_target_i = '0;
    do_reset();

    // correct taken prediction
    push(32'h100, 1'b1, 32'h80);
    res(32'h100, 1'b1, 32'h80);
    idle(2);
    // not-taken predicted, actually taken
    push(32'h104, 1'b0, 32'h0);
    res(32'h104, 1'b1, 32'h40);
    idle(3);
    // wrong target
    push(32'h200, 1'b1, 32'h200);
    res(32'h200, 1'b1, 32'h204);
    idle(3);
    // predicted taken, actually not taken: redirect to pc+4
    push(32'h300, 1'b1, 32'h400);
    res(32'h300, 1'b0, 32'h0);
    idle(3);
    // pc+4 wraps around the address space
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    res(32'hFFFF_FFFC, 1'b0, 32'h0);
    idle(3);

    // full queue with simultaneous push+pop, pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i) * 4, 1'b0, 32'h0);
    cyc(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    for (int i = 1; i < 5; i++) res(32'h10 + 32'(i) * 4, 1'b0, 32'h0);
    idle(1);
    // overflow: fifth push dropped, then drain four, then empty pop
    for (int i = 0; i < 5; i++) push(32'h40 + 32'(i) * 4, 1'b1, 32'h1000 + 32'(i));
    for (int i = 0; i < 4; i++) res(32'h40 + 32'(i) * 4, 1'b1, 32'h1000 + 32'(i));
    res(32'h50, 1'b0, 32'h0);
    idle(2);

    // pushes and resolves during flush are ignored
    do_reset();
    push(32'h500, 1'b0, 32'h0);
    cyc(1'b1, 32'h504, 1'b1, 32'h9, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600);
    cyc(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 1'b1, 32'h600, 1'b1, 32'h700);
    cyc(1'b1, 32'h604, 1'b0, 32'h0, 1'b0, 1'b1, 32'h604, 1'b0, 32'h0);
    res(32'h608, 1'b0, 32'h0);
    idle(2);

    // hold blocks push; resolve then hits an empty queue
    do_reset();
    cyc(1'b1, 32'h680, 1'b1, 32'h6C0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    res(32'h680, 1'b1, 32'h6C0);
    idle(3);

    // pc mismatch is a mispredict and an error
    do_reset();
    push(32'h700, 1'b1, 32'h800);
    res(32'h704, 1'b1, 32'h800);
    idle(3);

    // reset in the middle of a flush
    do_reset();
    push(32'h900, 1'b0, 32'h0);
    res(32'h900, 1'b1, 32'h940);
    idle(1);
    do_reset();
    push(32'h910, 1'b1, 32'h920);
    res(32'h910, 1'b1, 32'h920);
    idle(1);

    // counter saturation
    do_reset();
    force dut.branch_cnt_o  = 32'hFFFF_FFFE;
    force dut.mispred_cnt_o = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_o;
    release dut.mispred_cnt_o;
    m_bcnt = 32'hFFFF_FFFE;
    m_mcnt = 32'hFFFF_FFFF;
    push(32'hA00, 1'b0, 32'h0);
    res(32'hA00, 1'b1, 32'hA80);
    idle(3);
    push(32'hA04, 1'b0, 32'h0);
    res(32'hA04, 1'b0, 32'h0);
    idle(2);

    check("sb_empty_end", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
